// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: measures each half-period of an asynchronous heartbeat
// toggle, locks after a run of in-window half-periods, and reports faults
// and loss of heartbeat.
module heartbeat_monitor #(
  parameter int unsigned MIN_HALF   = 22_500_000,
  parameter int unsigned MAX_HALF   = 27_500_000,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned CNT_W      = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hb_in,
  output logic             alive,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             fault,
  output logic             lost
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  MIN_C  = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0]  MAX_C  = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0]  SAT_C  = CNT_W'(MAX_HALF + 1);
  localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_LOST    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t            state;
  logic              s1, s2, prev;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_inc;
  logic              hb_edge;
  logic              in_win;
  logic              timeout;

  assign hb_edge  = s2 ^ prev;
  assign in_win   = (cnt >= MIN_C) && (cnt <= MAX_C);
  assign timeout  = (cnt == SAT_C) && !hb_edge;
  assign good_inc = good + GOOD_W'(1);

  // Two-flop synchronizer plus previous-value register for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= hb_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Half-period counter: reloads to 1 on each edge, saturates one past the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hb_edge) begin
      cnt <= CNT_W'(1);
    end else if (cnt != SAT_C) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Supervision FSM with registered level and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOST;
      good        <= '0;
      alive       <= 1'b0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      fault       <= 1'b0;
      lost        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      fault      <= 1'b0;
      lost       <= 1'b0;
      case (state)
        ST_LOST: begin
          // First edge only arms the measurement; nothing to measure yet
          if (hb_edge) begin
            state <= ST_ACQUIRE;
            good  <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (hb_edge) begin
            half_period <= cnt;
            meas_valid  <= 1'b1;
            if (in_win) begin
              if (good_inc == LOCK_C) begin
                state <= ST_LOCKED;
                alive <= 1'b1;
                good  <= '0;
              end else begin
                good <= good_inc;
              end
            end else begin
              good <= '0;
            end
          end else if (timeout) begin
            state <= ST_LOST;
            good  <= '0;
            lost  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (hb_edge) begin
            half_period <= cnt;
            meas_valid  <= 1'b1;
            if (!in_win) begin
              state <= ST_ACQUIRE;
              good  <= '0;
              alive <= 1'b0;
              fault <= 1'b1;
            end
          end else if (timeout) begin
            state <= ST_LOST;
            good  <= '0;
            alive <= 1'b0;
            lost  <= 1'b1;
          end
        end
        default: begin
          state <= ST_LOST;
          good  <= '0;
          alive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Scoreboard bench for heartbeat_monitor: stimulus pushes hand-computed
// expected output events, a negedge monitor pops and compares them.
module tb_heartbeat_monitor;

  localparam int unsigned CW = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          hb_in = 1'b0;
  logic          alive;
  logic [CW-1:0] half_period;
  logic          meas_valid;
  logic          fault;
  logic          lost;

  typedef struct {
    int cyc;
    bit meas;
    int hp;
    bit flt;
    bit lst;
    bit alv;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc      = 0;
  int   errors   = 0;
  int   checks   = 0;
  int   last_tog = 0;

  heartbeat_monitor #(
    .MIN_HALF  (8),
    .MAX_HALF  (12),
    .LOCK_COUNT(3),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hb_in      (hb_in),
    .alive      (alive),
    .half_period(half_period),
    .meas_valid (meas_valid),
    .fault      (fault),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse the DUT presents must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (meas_valid || fault || lost)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got meas=%b hp=%0d fault=%b lost=%b alive=%b",
                 cyc, meas_valid, half_period, fault, lost, alive);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.meas != meas_valid || (e.meas && e.hp != int'(half_period)) ||
            e.flt != fault || e.lst != lost || e.alv != alive) begin
          errors++;
          $display("FAIL event got cyc=%0d meas=%b hp=%0d fault=%b lost=%b alive=%b exp cyc=%0d meas=%b hp=%0d fault=%b lost=%b alive=%b",
                   cyc, meas_valid, half_period, fault, lost, alive,
                   e.cyc, e.meas, e.hp, e.flt, e.lst, e.alv);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle hb_in gap cycles after the previous toggle; output follows 3 clocks later
  task automatic tog(input int gap, input bit ev, input int hp, input bit flt, input bit alv);
    tick(gap);
    hb_in    = ~hb_in;
    last_tog = cyc;
    if (ev) sb.push_back('{cyc + 3, 1'b1, hp, flt, 1'b0, alv});
  endtask

  // Timeout: cnt loads 3 clocks after the toggle, lost follows 13 clocks later
  task automatic expect_lost();
    sb.push_back('{last_tog + 16, 1'b0, 0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;

    // Idle input: stays in LOST, no pulses at all
    tick(100);
    chk("idle_alive", int'(alive), 0);
    chk("idle_half_period", int'(half_period), 0);
    chk("idle_meas_valid", int'(meas_valid), 0);
    chk("idle_fault", int'(fault), 0);
    chk("idle_lost", int'(lost), 0);

    // 10-cycle toggles: lock on the 4th edge
    tog(10, 0, 0, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 1);
    tog(10, 1, 10, 0, 1);

    // Short half-period while locked, then relock
    tog(5, 1, 5, 1, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 1);

    // Heartbeat stops: lost pulse, then re-arm without measurement
    expect_lost();
    tick(30);
    chk("alive_after_lost", int'(alive), 0);
    tog(5, 0, 0, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 1);

    // Window boundaries
    tog(8, 1, 8, 0, 1);
    tog(12, 1, 12, 0, 1);
    tog(7, 1, 7, 1, 0);
    tog(13, 1, 13, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 1);
    tog(13, 1, 13, 1, 0);

    // Relock, then reset mid-half-period
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 1);
    tick(4);
    chk("alive_before_reset", int'(alive), 1);
    chk("sb_empty_before_reset", sb.size(), 0);
    hb_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_alive", int'(alive), 0);
    chk("rst_half_period", int'(half_period), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_lost", int'(lost), 0);
    tick(3);
    rst_n = 1'b1;
    tog(10, 0, 0, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 0);
    tog(10, 1, 10, 0, 1);
    tick(10);
    chk("alive_after_relock", int'(alive), 1);
    chk("sb_empty_at_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
